// File: rtl/chacha_pkg.sv
// Shared ChaCha20 keystream constants, the buffered block record and slice helpers.
package chacha_pkg;

    localparam int CHACHA_BLK_W = 512;
    localparam int OTK_W        = 256;
    localparam int CTR_W        = 32;

    // One buffered keystream block together with the block counter it was generated for
    typedef struct packed {
        logic [CTR_W-1:0]        ctr;
        logic [CHACHA_BLK_W-1:0] data;
    } ks_entry_t;

    // Number of OUT_W-bit slices that make up one 512-bit block
    function automatic int slices_per_block(input int out_w);
        return CHACHA_BLK_W / out_w;
    endfunction

endpackage

// File: rtl/ks_blk_fifo.sv
// Small block buffer: DEPTH entries of {ctr, 512-bit block}, one write and one read port,
// registered occupancy. The read side is show-ahead (head entry always visible).
module ks_blk_fifo
    import chacha_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  ks_entry_t        wr_data,
    input  logic             rd_en,
    output ks_entry_t        rd_data,
    output logic [LVL_W-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    ks_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    // Payload storage; contents need no reset because occ gates every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; a flush clears everything, write and pop together hold occ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + LVL_W'(1);
                2'b01:   occ <= occ - LVL_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/chacha20_ks_stream.sv
// Keystream prefetch/slicing stage: requests blocks from the ChaCha20 core with an explicit
// counter, buffers them, and serves OUT_W-bit slices LSB-first; optionally the first
// returned block is diverted to the Poly1305 one-time-key port.
module chacha20_ks_stream
    import chacha_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OUT_W = 128,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CTR_W-1:0]        ctr_init,
    input  logic                    otk_en,
    input  logic                    run,
    output logic                    ks_req,
    output logic [CTR_W-1:0]        ks_ctr,
    input  logic                    ks_valid,
    input  logic [CHACHA_BLK_W-1:0] ks_data,
    output logic                    ks_out_valid,
    input  logic                    ks_out_ready,
    output logic [OUT_W-1:0]        ks_out_data,
    output logic [CTR_W-1:0]        ks_out_ctr,
    output logic                    ks_out_last,
    output logic                    otk_valid,
    output logic [OTK_W-1:0]        otk_data,
    output logic                    ctr_exhausted,
    output logic [LVL_W-1:0]        level
);

    localparam int SPB    = slices_per_block(OUT_W);
    localparam int SIDX_W = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int BASE_W = $clog2(CHACHA_BLK_W);
    localparam logic [LVL_W-1:0]  DEPTH_L   = LVL_W'(DEPTH);
    localparam logic [SIDX_W-1:0] SIDX_LAST = SIDX_W'(SPB - 1);

    logic              outst;
    logic              discard;
    logic              otk_pend;
    logic              exh;
    logic [CTR_W:0]    nxt_ctr;
    logic [SIDX_W-1:0] sidx;
    logic [LVL_W-1:0]  occ;
    logic [BASE_W-1:0] base;
    ks_entry_t         head;
    ks_entry_t         wr_entry;
    logic              issue;
    logic              resp;
    logic              buf_wr;
    logic              pop;
    logic              slice_last;

    // With at most one request in flight, occ + outst < DEPTH reduces to occ < DEPTH once !outst
    assign issue      = run & ~cfg_we & ~outst & ~exh & (occ < DEPTH_L);
    assign resp       = ks_valid & outst & ~cfg_we;
    assign buf_wr     = resp & ~discard & ~otk_pend;
    assign slice_last = (sidx == SIDX_LAST);
    assign pop        = ks_out_valid & ks_out_ready & slice_last & ~cfg_we;
    assign wr_entry   = '{ctr: ks_ctr, data: ks_data};

    assign ks_out_valid  = (occ != '0);
    assign ks_out_last   = ks_out_valid & slice_last;
    assign level         = occ;
    assign ctr_exhausted = exh;

    ks_blk_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cfg_we),
        .wr_en   (buf_wr),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .occ     (occ)
    );

    // Select the current slice of the head block; outputs are forced to zero while empty
    always_comb begin
        base        = BASE_W'(int'(sidx) * OUT_W);
        ks_out_data = '0;
        ks_out_ctr  = '0;
        if (ks_out_valid) begin
            ks_out_data = head.data[base +: OUT_W];
            ks_out_ctr  = head.ctr;
        end
    end

    // Request issue, response bookkeeping and configuration flush (flush wins over everything)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_req    <= 1'b0;
            ks_ctr    <= '0;
            outst     <= 1'b0;
            discard   <= 1'b0;
            otk_pend  <= 1'b0;
            exh       <= 1'b0;
            nxt_ctr   <= '0;
            otk_valid <= 1'b0;
            otk_data  <= '0;
        end else begin
            ks_req    <= issue;
            otk_valid <= 1'b0;
            if (cfg_we) begin
                nxt_ctr  <= {1'b0, ctr_init};
                otk_pend <= otk_en;
                exh      <= 1'b0;
                if (outst && !ks_valid) begin
                    discard <= 1'b1;
                end else begin
                    outst   <= 1'b0;
                    discard <= 1'b0;
                end
            end else begin
                if (issue) begin
                    ks_ctr  <= nxt_ctr[CTR_W-1:0];
                    outst   <= 1'b1;
                    nxt_ctr <= nxt_ctr + (CTR_W + 1)'(1);
                    if (nxt_ctr[CTR_W-1:0] == '1) begin
                        exh <= 1'b1;
                    end
                end
                if (resp) begin
                    outst <= 1'b0;
                    if (discard) begin
                        discard <= 1'b0;
                    end else if (otk_pend) begin
                        otk_valid <= 1'b1;
                        otk_data  <= ks_data[OTK_W-1:0];
                        otk_pend  <= 1'b0;
                    end
                end
            end
        end
    end

    // Slice index advances on every accepted slice and wraps after the last one of a block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sidx <= '0;
        end else if (cfg_we) begin
            sidx <= '0;
        end else if (ks_out_valid && ks_out_ready) begin
            sidx <= slice_last ? '0 : sidx + SIDX_W'(1);
        end
    end

endmodule

// File: tb/tb_chacha20_ks_stream.sv
// Self-checking bench for chacha20_ks_stream: core latency model, slice/OTK scoreboard,
// a table of stream configurations and hand-written corner-case sequences.
module tb_chacha20_ks_stream;
    import chacha_pkg::*;

    localparam int DEPTH = 2;
    localparam int OUT_W = 128;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int SPB   = 512 / OUT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [31:0]        ctr_init = '0;
    logic               otk_en = 1'b0;
    logic               run = 1'b0;
    logic               ks_valid = 1'b0;
    logic [511:0]       ks_data = '0;
    logic               ks_out_ready = 1'b0;
    logic               ks_req;
    logic [31:0]        ks_ctr;
    logic               ks_out_valid;
    logic [OUT_W-1:0]   ks_out_data;
    logic [31:0]        ks_out_ctr;
    logic               ks_out_last;
    logic               otk_valid;
    logic [255:0]       otk_data;
    logic               ctr_exhausted;
    logic [LVL_W-1:0]   level;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [31:0]      ctr;
        logic             last;
    } slice_t;

    typedef struct {
        logic [31:0] ctr_init;
        logic        otk;
        int          lat;
        bit          rnd;
        logic [31:0] exp_first;
        int          exp_otk;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          core_lat = 10;
    bit          ready_hold = 1'b0;
    bit          ready_rand = 1'b0;

    slice_t      exp_q[$];
    logic [255:0] otk_q[$];
    bit          m_outst, m_discard, m_otk_pend, m_exh;
    logic [32:0] m_ctr;
    logic [31:0] m_req_ctr;
    int          req_cnt, acc_cnt, otk_cnt;
    logic [31:0] first_ctr;
    bit          first_seen;

    chacha20_ks_stream #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .ctr_init      (ctr_init),
        .otk_en        (otk_en),
        .run           (run),
        .ks_req        (ks_req),
        .ks_ctr        (ks_ctr),
        .ks_valid      (ks_valid),
        .ks_data       (ks_data),
        .ks_out_valid  (ks_out_valid),
        .ks_out_ready  (ks_out_ready),
        .ks_out_data   (ks_out_data),
        .ks_out_ctr    (ks_out_ctr),
        .ks_out_last   (ks_out_last),
        .otk_valid     (otk_valid),
        .otk_data      (otk_data),
        .ctr_exhausted (ctr_exhausted),
        .level         (level)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Deterministic keystream content per block counter, distinct per 32-bit word
    function automatic logic [511:0] make_blk(input logic [31:0] c);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*32 +: 32] = {c[27:0], 4'(i)} ^ 32'hC3A5_0000;
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ctr, input logic otk, input int lat);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        ctr_init = ctr;
        otk_en   = otk;
        core_lat = lat;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitReq(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (ks_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitAccepts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (acc_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Consumer ready: forced low, always high or random
    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            ks_out_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ChaCha20 core model: answers each request after core_lat cycles
    initial begin : core_model
        bit          busy;
        int          cnt;
        logic [31:0] cctr;
        busy = 1'b0;
        cnt  = 0;
        cctr = '0;
        forever begin
            @(posedge clk); #1;
            ks_valid = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (cnt <= 0) begin
                        ks_valid = 1'b1;
                        ks_data  = make_blk(cctr);
                        busy     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (ks_req) begin
                    busy = 1'b1;
                    cctr = ks_ctr;
                    cnt  = core_lat - 1;
                end
            end
        end
    end

    // Scoreboard: model request/response/flush behaviour and compare every slice and OTK pulse
    initial begin : monitor
        slice_t       s;
        logic [511:0] b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                otk_q.delete();
                m_outst = 0; m_discard = 0; m_otk_pend = 0; m_exh = 0;
                m_ctr = '0; m_req_ctr = '0;
                req_cnt = 0; acc_cnt = 0; otk_cnt = 0;
                first_seen = 0; first_ctr = '0;
            end else begin
                if (ks_out_valid && ks_out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("slice_unexpected", ks_out_valid, 1'b0);
                    end else begin
                        s = exp_q.pop_front();
                        checkOutput("slice_data", ks_out_data, s.data);
                        checkOutput("slice_ctr", ks_out_ctr, s.ctr);
                        checkOutput("slice_last", ks_out_last, s.last);
                    end
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        first_ctr  = ks_out_ctr;
                    end
                    acc_cnt++;
                end
                if (otk_valid) begin
                    otk_cnt++;
                    if (otk_q.size() == 0) checkOutput("otk_unexpected", otk_valid, 1'b0);
                    else checkOutput("otk_data", otk_data, otk_q.pop_front());
                end
                if (ks_req) begin
                    req_cnt++;
                    checkOutput("req_while_outstanding", m_outst, 1'b0);
                    checkOutput("req_after_exh", m_exh, 1'b0);
                    checkOutput("req_ctr", ks_ctr, m_ctr[31:0]);
                    if (m_ctr[31:0] == 32'hFFFF_FFFF) m_exh = 1'b1;
                    m_req_ctr = m_ctr[31:0];
                    m_ctr     = m_ctr + 33'd1;
                    m_outst   = 1'b1;
                end
                if (cfg_we) begin
                    exp_q.delete();
                    m_ctr      = {1'b0, ctr_init};
                    m_exh      = 1'b0;
                    m_otk_pend = otk_en;
                    if (m_outst && !ks_valid) begin
                        m_discard = 1'b1;
                    end else begin
                        m_outst   = 1'b0;
                        m_discard = 1'b0;
                    end
                    req_cnt = 0; acc_cnt = 0; otk_cnt = 0; first_seen = 0;
                end else if (ks_valid && m_outst) begin
                    m_outst = 1'b0;
                    b = make_blk(m_req_ctr);
                    if (m_discard) begin
                        m_discard = 1'b0;
                    end else if (m_otk_pend) begin
                        m_otk_pend = 1'b0;
                        otk_q.push_back(b[255:0]);
                    end else begin
                        for (int j = 0; j < SPB; j++) begin
                            s.data = b[j*OUT_W +: OUT_W];
                            s.ctr  = m_req_ctr;
                            s.last = (j == SPB - 1);
                            exp_q.push_back(s);
                        end
                    end
                end
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        vec_t         vecs[4];
        bit           ok;
        logic [511:0] b5;

        vecs[0] = '{32'd5,     1'b0, 10, 1'b0, 32'd5,    0};
        vecs[1] = '{32'd0,     1'b1, 3,  1'b0, 32'd1,    1};
        vecs[2] = '{32'd1000,  1'b0, 1,  1'b1, 32'd1000, 0};
        vecs[3] = '{32'h10,    1'b1, 2,  1'b1, 32'h11,   1};

        rst_n = 1'b0;
        waitCycles(3);
        checkOutput("rst_ks_req", ks_req, 1'b0);
        checkOutput("rst_out_valid", ks_out_valid, 1'b0);
        checkOutput("rst_level", level, '0);
        checkOutput("rst_exhausted", ctr_exhausted, 1'b0);
        checkOutput("rst_otk_valid", otk_valid, 1'b0);
        checkOutput("rst_out_data", ks_out_data, '0);
        checkOutput("rst_ks_ctr", ks_ctr, '0);
        rst_n = 1'b1;
        waitCycles(2);

        // Table of stream configurations; scoreboard checks every slice on the way
        for (int v = 0; v < 4; v++) begin
            ready_hold = 1'b0;
            ready_rand = vecs[v].rnd;
            applyStimulus(vecs[v].ctr_init, vecs[v].otk, vecs[v].lat);
            run = 1'b1;
            waitAccepts(12, 400, ok);
            checkOutput("vec_done", ok, 1'b1);
            checkOutput("vec_first_ctr", first_ctr, vecs[v].exp_first);
            checkOutput("vec_otk_cnt", otk_cnt, vecs[v].exp_otk);
        end

        // Backpressure: two blocks fill the buffer, head slice held, no refill before pop
        run = 1'b0;
        ready_hold = 1'b1;
        ready_rand = 1'b0;
        applyStimulus(32'd5, 1'b0, 10);
        run = 1'b1;
        waitCycles(50);
        b5 = make_blk(32'd5);
        checkOutput("bp_req_cnt", req_cnt, 2);
        checkOutput("bp_level", level, 2);
        checkOutput("bp_valid", ks_out_valid, 1'b1);
        checkOutput("bp_head_data", ks_out_data, b5[127:0]);
        checkOutput("bp_head_ctr", ks_out_ctr, 32'd5);
        waitCycles(5);
        checkOutput("bp_hold_data", ks_out_data, b5[127:0]);
        ready_hold = 1'b0;
        waitAccepts(3, 50, ok);
        checkOutput("bp_accepts", ok, 1'b1);
        checkOutput("bp_no_early_req", req_cnt, 2);
        waitCycles(40);

        // Counter wrap: only FFFFFFFE and FFFFFFFF are requested, both delivered
        run = 1'b0;
        applyStimulus(32'hFFFF_FFFE, 1'b0, 4);
        run = 1'b1;
        waitCycles(80);
        checkOutput("wrap_req_cnt", req_cnt, 2);
        checkOutput("wrap_exhausted", ctr_exhausted, 1'b1);
        checkOutput("wrap_slices", acc_cnt, 2 * SPB);
        checkOutput("wrap_level", level, '0);

        // Flush with a request in flight: stale block dropped, next request uses new counter
        run = 1'b0;
        ready_hold = 1'b1;
        applyStimulus(32'd50, 1'b0, 10);
        checkOutput("flush_exh_clear", ctr_exhausted, 1'b0);
        run = 1'b1;
        waitReq(20, ok);
        checkOutput("flush_first_req", ok, 1'b1);
        waitCycles(2);
        applyStimulus(32'd100, 1'b0, 10);
        waitReq(40, ok);
        checkOutput("flush_second_req", ok, 1'b1);
        checkOutput("flush_ctr", ks_ctr, 32'd100);
        checkOutput("flush_level", level, '0);

        // Asynchronous reset between clock edges in the middle of a stream
        ready_hold = 1'b0;
        ready_rand = 1'b1;
        applyStimulus(32'd7, 1'b0, 3);
        waitCycles(20);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ks_req", ks_req, 1'b0);
        checkOutput("arst_out_valid", ks_out_valid, 1'b0);
        checkOutput("arst_level", level, '0);
        checkOutput("arst_out_data", ks_out_data, '0);
        checkOutput("arst_out_last", ks_out_last, 1'b0);
        checkOutput("arst_otk_valid", otk_valid, 1'b0);
        checkOutput("arst_exhausted", ctr_exhausted, 1'b0);
        run = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        waitCycles(5);
        checkOutput("arst_no_req", req_cnt, 0);
        run = 1'b1;
        waitReq(10, ok);
        checkOutput("arst_req_after_run", ok, 1'b1);
        checkOutput("arst_first_ctr", ks_ctr, 32'd0);
        waitCycles(30);
        run = 1'b0;
        waitCycles(20);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chacha20_ks_stream.md
# chacha20_ks_stream

Parametrised keystream prefetch and slicing stage between the ChaCha20 block core and the payload XOR datapath. It issues one-block keystream requests to the core with an explicit block counter and buffers up to DEPTH 512-bit blocks. It serves them as OUT_W-bit slices over a valid/ready handshake. Optionally it diverts the first block to a Poly1305 one-time-key port.

## Interface
- DEPTH, 2, buffered 512-bit blocks; 1..8
- OUT_W, 128, slice width; one of 32/64/128/256/512
- LVL_W, $clog2(DEPTH+1), width of the level output; derived, do not override
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  sync load/flush: loads ctr_init, samples otk_en, clears buffer
- ctr_init  in  32  first block counter
- otk_en  in  1  divert first returned block to otk port
- run  in  1  enables issuing requests
- ks_req  out  1  one-cycle request pulse to core
- ks_ctr  out  32  block counter for the request; valid while ks_req is high
- ks_valid  in  1  one-cycle core response pulse
- ks_data  in  512  core keystream block
- ks_out_valid  out  1  slice available
- ks_out_ready  in  1  consumer accepts slice
- ks_out_data  out  OUT_W  current slice
- ks_out_ctr  out  32  block counter of the current slice
- ks_out_last  out  1  current slice is the final slice of its block
- otk_valid  out  1  one-cycle pulse, one-time key ready
- otk_data  out  256  ks_data[255:0] of the diverted block
- ctr_exhausted  out  1  sticky; counter space used up
- level  out  LVL_W  buffered blocks

## Operation
- State:
  - wr/rd pointers, occupancy `occ`
  - `outst` flag: a request is in flight
  - `discard` flag
  - `nxt_ctr` (33-bit internally)
  - slice index `sidx` (0..512/OUT_W-1)
  - `otk_pend`
  - `exh`
- Request issue: ks_req=1 when run & !outst & !exh & (occ + outst < DEPTH). Use registered occ; a pop in the same cycle does not free a slot until the next cycle.
- On issue:
  - ks_ctr = nxt_ctr[31:0]
  - outst←1
  - nxt_ctr←nxt_ctr+1
  - if nxt_ctr==32'hFFFFFFFF, exh←1, so no further issue
- At most one request is outstanding.
- Response handling with ks_valid & outst: outst←0.
  - If discard: drop the block and clear discard.
  - Else if otk_pend: otk_valid pulses next cycle, otk_data registered, otk_pend←0, no buffer write.
  - Else: write {ks_data, ctr} at wr_ptr and occ+1.
- ks_valid without outst is ignored.
- Slicing: ks_out_data = entry[sidx*OUT_W +: OUT_W], LSB slice first.
  - On each accept, sidx increments.
  - On accepting the last slice: sidx←0, pop, occ−1.
- Simultaneous write and pop: occ unchanged.
- The otk block consumes the counter like any request; stream blocks start at ctr_init+1 when otk_en=1.
- cfg_we (priority over all updates in that cycle):
  - occ, pointers, sidx, exh ← 0
  - nxt_ctr←ctr_init
  - otk_pend←otk_en
  - if outst (and no ks_valid this cycle) discard←1, outst stays 1; else outst←0
  - a ks_valid in the same cycle as cfg_we is dropped
- No request issues in the cfg_we cycle.
- Reset: every output 0; state as after cfg_we with ctr_init=0, otk_en=0, outst=0, discard=0.

## Timing
- ks_req is registered and is high exactly one cycle per issue.
- Write at the ks_valid edge; ks_out_valid high from the next cycle (1-cycle response-to-output latency).
- Handshake: the slice transfers when ks_out_valid & ks_out_ready. Data and ctr stay stable while valid & !ready.
- Full-rate output: one slice per cycle while occ>0.
- level = occ, registered.
- ctr_exhausted = exh, registered, cleared only by cfg_we or reset.

## Structure
- Shared package `chacha_pkg`:
  - CHACHA_BLK_W=512
  - OTK_W=256
  - CTR_W=32
  - a function for slices-per-block
- One sub-module `ks_blk_fifo` (DEPTH × (512+32), single write, single read, occ tracking).
- Request/slice control stays in the top.

## Test plan
- Basic stream: DEPTH=2, OUT_W=128, ctr_init=5, run=1, core model 10-cycle latency -> requests with ctr 5,6,7…, four slices per block in LSB-first order, ks_out_last on the 4th, ks_out_ctr matches.
- Backpressure: ks_out_ready=0 for 50 cycles -> exactly 2 requests issued, level=2, no ks_req until the first block is fully popped, data held stable.
- OTK mode: otk_en=1, ctr_init=0 -> otk_valid one pulse with ks_data[255:0] of ctr 0; first stream slice has ks_out_ctr=1.
- Counter wrap: ctr_init=32'hFFFFFFFE -> requests for FFFFFFFE and FFFFFFFF only, ctr_exhausted=1, no further ks_req, both blocks delivered.
- Flush mid-flight: cfg_we with a request outstanding, ctr_init=100 -> the stale response is discarded (level stays 0), next request carries ctr 100.
- Async reset mid-stream: rst_n low between clock edges -> all outputs 0 immediately, no ks_req until run after release.
